// File: rtl/svc_rv_hazard_sb.sv
// Producer-side hazard detection and long-latency scoreboard for the RV pipeline.
// Drives IF/ID stalls and the EX bubble until a needed value becomes forwardable.
module svc_rv_hazard_sb #(
    parameter int MEM_TYPE = 0,
    parameter int MAX_LONG = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic [4:0]       rd_id,
    input  logic             reg_write_id,
    input  logic             long_op_id,
    input  logic             issue,
    input  logic             flush,
    input  logic [4:0]       rd_ex,
    input  logic             reg_write_ex,
    input  logic [2:0]       res_src_ex,
    input  logic [4:0]       rd_mem,
    input  logic             reg_write_mem,
    input  logic [2:0]       res_src_mem,
    input  logic             lo_done,
    input  logic [4:0]       lo_rd,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             lo_full,
    output logic [31:0]      pending,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int LW = (MAX_LONG < 2) ? 1 : $clog2(MAX_LONG + 1);

    logic [31:0]      pending_q, pending_d;
    logic [LW-1:0]    lo_cnt_q, lo_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             m_ex, m_mem;
    logic             h_sb, h_waw, h_full, h_ld, h_csr, h_bram, hz, stall;
    logic             sb_set, sb_clr;

    always_comb begin
        m_ex  = (rd_ex  != 5'd0) && ((rd_ex  == rs1_id) || (rd_ex  == rs2_id));
        m_mem = (rd_mem != 5'd0) && ((rd_mem == rs1_id) || (rd_mem == rs2_id));

        h_sb   = ((rs1_id != 5'd0) && pending_q[rs1_id]) ||
                 ((rs2_id != 5'd0) && pending_q[rs2_id]);
        h_waw  = long_op_id && reg_write_id && (rd_id != 5'd0) && pending_q[rd_id];
        h_full = long_op_id && lo_full;
        h_ld   = reg_write_ex && (res_src_ex == 3'd1) && m_ex;
        h_csr  = (reg_write_ex  && (res_src_ex  == 3'd4) && m_ex) ||
                 (reg_write_mem && (res_src_mem == 3'd4) && m_mem);
        h_bram = (MEM_TYPE == 1) && reg_write_mem && (res_src_mem == 3'd1) && m_mem;

        hz    = h_sb || h_waw || h_full || h_ld || h_csr || h_bram;
        // Gated by rst_n so the pipeline never sees a stall while reset is held.
        stall = hz && !flush && rst_n;
    end

    assign stall_if  = stall;
    assign stall_id  = stall;
    assign bubble_ex = stall;
    assign lo_full   = (lo_cnt_q == LW'(MAX_LONG));
    assign pending   = pending_q;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        sb_set = issue && !hz && !flush && long_op_id && reg_write_id && (rd_id != 5'd0);
        sb_clr = lo_done && (lo_rd != 5'd0) && pending_q[lo_rd];

        // Set is applied after clear so it wins on a same-register collision.
        pending_d = pending_q;
        if (sb_clr) pending_d[lo_rd] = 1'b0;
        if (sb_set) pending_d[rd_id] = 1'b1;
        pending_d[0] = 1'b0;

        lo_cnt_d = lo_cnt_q;
        if (sb_set && !sb_clr) lo_cnt_d = lo_cnt_q + LW'(1);
        else if (sb_clr && !sb_set) lo_cnt_d = lo_cnt_q - LW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            lo_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            pending_q <= pending_d;
            lo_cnt_q  <= lo_cnt_d;
            if (stall && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

endmodule
